// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch stage, instruction memory, decode and the branch unit.
// The master modport is the fetch stage; the slave modport is everything around it.
interface fetch_unit_if #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 28
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_base_pc;
  logic [23:0]        br_imm_ext;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, br_taken, br_base_pc, br_imm_ext
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, br_taken, br_base_pc, br_imm_ext
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request and hands it to decode.
// Branch redirects override everything except reset and pass through a one-cycle bubble.
module fetch_unit #(
  parameter int ADDR_W   = 24,
  parameter int INSTR_W  = 28,
  parameter int RESET_PC = 0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_BUBBLE = 2'd2
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  pc_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  instr_pc_r;
  logic               req_r;
  logic               valid_r;

  logic [ADDR_W-1:0]  imm_s;
  logic [ADDR_W-1:0]  target_s;

  // Offset is in words; the sum wraps modulo 2^ADDR_W and the carry is dropped.
  assign imm_s    = ADDR_W'($signed(bus.br_imm_ext));
  assign target_s = bus.br_base_pc + ADDR_W'(1) + imm_s;

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;

  // Fetch state machine; req_r/valid_r track the next state so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      pc_r       <= ADDR_W'(RESET_PC);
      instr_r    <= {INSTR_W{1'b0}};
      instr_pc_r <= {ADDR_W{1'b0}};
      req_r      <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (bus.br_taken) begin
            pc_r    <= target_s;
            state_r <= ST_BUBBLE;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
          end else if (bus.imem_ack && req_r) begin
            instr_r    <= bus.imem_rdata;
            instr_pc_r <= pc_r;
            state_r    <= ST_HOLD;
            req_r      <= 1'b0;
            valid_r    <= 1'b1;
          end else begin
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (bus.br_taken) begin
            pc_r    <= target_s;
            state_r <= ST_BUBBLE;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
          end else if (bus.instr_ready) begin
            pc_r    <= pc_r + ADDR_W'(1);
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        ST_BUBBLE: begin
          // A newer redirect restarts the bubble so the abandoned request never sees a live req.
          if (bus.br_taken) begin
            pc_r    <= target_s;
            state_r <= ST_BUBBLE;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
          end else begin
            state_r <= ST_FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_FETCH;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus pushes expected deliveries, a negedge monitor checks them.
module tb_fetch_unit;
  localparam int AW = 24;
  localparam int IW = 28;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus_if();

  fetch_unit #(.ADDR_W(AW), .INSTR_W(IW), .RESET_PC(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && bus_if.instr_valid && bus_if.instr_ready && !bus_if.br_taken) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL accept_unexpected: got pc 0x%0h instr 0x%0h want none",
                 bus_if.instr_pc, bus_if.instr);
      end else begin
        e = exp_q.pop_front();
        chk("accept_instr", 32'(bus_if.instr), 32'(e.instr));
        chk("accept_pc", 32'(bus_if.instr_pc), 32'(e.pc));
      end
    end
  end

  // From FETCH at address a: memory acks two cycles after the request, leaving the DUT in HOLD.
  task automatic fetch_to_hold(input logic [AW-1:0] a, input logic [IW-1:0] d, input bit push);
    chk("req_on", 32'(bus_if.imem_req), 32'd1);
    chk("req_addr", 32'(bus_if.imem_addr), 32'(a));
    step();
    chk("addr_stable", 32'(bus_if.imem_addr), 32'(a));
    step();
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = d;
    if (push) exp_q.push_back({d, a});
    step();
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 28'h0;
    chk("valid_after_ack", 32'(bus_if.instr_valid), 32'd1);
    chk("req_off_hold", 32'(bus_if.imem_req), 32'd0);
  endtask

  task automatic accept_and_next(input logic [AW-1:0] a);
    logic [AW-1:0] n;
    n = a + 24'd1;
    bus_if.instr_ready = 1'b1;
    step();
    bus_if.instr_ready = 1'b0;
    chk("valid_drop", 32'(bus_if.instr_valid), 32'd0);
    chk("next_req", 32'(bus_if.imem_req), 32'd1);
    chk("next_addr", 32'(bus_if.imem_addr), 32'(n));
  endtask

  task automatic branch(input logic [AW-1:0] base, input logic [23:0] imm);
    bus_if.br_taken   = 1'b1;
    bus_if.br_base_pc = base;
    bus_if.br_imm_ext = imm;
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.imem_ack    = 1'b0;
    bus_if.imem_rdata  = 28'h0;
    bus_if.instr_ready = 1'b0;
    bus_if.br_taken    = 1'b0;
    bus_if.br_base_pc  = 24'h0;
    bus_if.br_imm_ext  = 24'h0;
    repeat (3) step();
    chk("rst_req", 32'(bus_if.imem_req), 32'd0);
    chk("rst_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_instr", 32'(bus_if.instr), 32'd0);
    chk("rst_instr_pc", 32'(bus_if.instr_pc), 32'd0);
    chk("rst_addr", 32'(bus_if.imem_addr), 32'd0);
    reset = 1'b0;
    step();

    // Basic fetch at 0 then 1
    fetch_to_hold(24'h0, 28'h1234567, 1'b1);
    accept_and_next(24'h0);

    // Decode stall for 5 cycles
    fetch_to_hold(24'h1, 28'hABCDEF0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus_if.instr_valid), 32'd1);
      chk("stall_instr", 32'(bus_if.instr), 32'h0ABCDEF0);
      chk("stall_pc", 32'(bus_if.instr_pc), 32'h1);
      chk("stall_req", 32'(bus_if.imem_req), 32'd0);
    end
    accept_and_next(24'h1);

    // Forward branch from FETCH: 0x10 + 1 + 5
    branch(24'h000010, 24'h000005);
    step();
    bus_if.br_taken = 1'b0;
    chk("bubble_req", 32'(bus_if.imem_req), 32'd0);
    chk("bubble_valid", 32'(bus_if.instr_valid), 32'd0);
    step();
    chk("br_fwd_req", 32'(bus_if.imem_req), 32'd1);
    chk("br_fwd_addr", 32'(bus_if.imem_addr), 32'h000016);

    // Negative offset wraps below zero: 2 + 1 - 4
    branch(24'h000002, 24'hFFFFFC);
    step();
    bus_if.br_taken = 1'b0;
    step();
    chk("br_wrap_addr", 32'(bus_if.imem_addr), 32'h00FFFFFF);
    fetch_to_hold(24'hFFFFFF, 28'h0FEDCBA, 1'b1);
    accept_and_next(24'hFFFFFF);

    // Branch coincident with ack in FETCH: data dropped
    step();
    step();
    bus_if.imem_ack    = 1'b1;
    bus_if.imem_rdata  = 28'hDEADBEE;
    bus_if.instr_ready = 1'b1;
    branch(24'h000100, 24'h000020);
    step();
    bus_if.imem_ack = 1'b0;
    bus_if.br_taken = 1'b0;
    chk("drop_valid0", 32'(bus_if.instr_valid), 32'd0);
    chk("drop_req0", 32'(bus_if.imem_req), 32'd0);
    step();
    chk("drop_valid1", 32'(bus_if.instr_valid), 32'd0);
    chk("drop_addr", 32'(bus_if.imem_addr), 32'h000121);
    bus_if.instr_ready = 1'b0;

    // Branch squashes a held instruction even with ready high
    fetch_to_hold(24'h000121, 28'h5555555, 1'b0);
    bus_if.instr_ready = 1'b1;
    branch(24'h000200, 24'h000000);
    step();
    bus_if.br_taken    = 1'b0;
    bus_if.instr_ready = 1'b0;
    chk("squash_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("squash_req", 32'(bus_if.imem_req), 32'd0);
    step();
    chk("squash_addr", 32'(bus_if.imem_addr), 32'h000201);

    // Second branch during BUBBLE takes the newer target
    branch(24'h000300, 24'h000001);
    step();
    branch(24'h000400, 24'h000002);
    step();
    bus_if.br_taken = 1'b0;
    chk("rebubble_req", 32'(bus_if.imem_req), 32'd0);
    step();
    chk("rebubble_addr", 32'(bus_if.imem_addr), 32'h000403);

    // Reset wins over ready and branch in HOLD
    fetch_to_hold(24'h000403, 28'h7777777, 1'b0);
    bus_if.instr_ready = 1'b1;
    branch(24'h000500, 24'h000007);
    reset = 1'b1;
    step();
    chk("rst_mid_valid", 32'(bus_if.instr_valid), 32'd0);
    chk("rst_mid_req", 32'(bus_if.imem_req), 32'd0);
    chk("rst_mid_pc", 32'(bus_if.imem_addr), 32'd0);
    chk("rst_mid_instr", 32'(bus_if.instr), 32'd0);
    reset              = 1'b0;
    bus_if.br_taken    = 1'b0;
    bus_if.instr_ready = 1'b0;
    step();
    fetch_to_hold(24'h0, 28'h1234567, 1'b1);
    accept_and_next(24'h0);

    step();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
